mdu: RTL and testbench

Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It takes the same forwarded `srcA`/`srcB` operands as the ALU. It executes `mult`, `multu`, `div` and `divu` as multi-cycle operations into the architectural HI/LO registers, and executes `mthi`/`mtlo` as single-cycle writes. HI/LO values feed the EX result mux beside `ALUout` for `mfhi`/`mflo`. `busy` and `md_stall` drive the hazard unit.

---
 rtl/mdu.sv | 128 ++++++++++++
 tb/tb_mdu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: multi-cycle mult/div into HI/LO plus
// single-cycle mthi/mtlo, with busy/md_stall feeding the hazard unit.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [2:0]  MDop,
    input  logic        start,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [0:0]         state;
    logic [CW-1:0]      count;
    logic [31:0]        hi_n;
    logic [31:0]        lo_n;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               md_op;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    assign md_op    = (MDop != 3'b000) && (MDop <= OP_DIVU);
    assign busy     = (state == RUN);
    assign md_stall = busy | (start & md_op);

    // The whole result is formed at issue; RUN only models the fixed latency.
    assign prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
    assign prod_u = {32'b0, srcA} * {32'b0, srcB};
    assign quo_s  = $signed(srcA) / $signed(srcB);
    assign rem_s  = $signed(srcA) % $signed(srcB);
    assign quo_u  = srcA / srcB;
    assign rem_u  = srcA % srcB;

    always_comb begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        case (MDop)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_DIV: begin
                if (srcB == 32'b0) begin
                    res_hi = srcA;
                    res_lo = 32'hFFFF_FFFF;
                end else if (srcA == 32'h8000_0000 && srcB == 32'hFFFF_FFFF) begin
                    res_hi = 32'b0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            OP_DIVU: begin
                if (srcB == 32'b0) begin
                    res_hi = srcA;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            default: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
        endcase
    end

    // Any start seen while RUN is dropped; the hazard unit re-issues it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            hi_n  <= 32'b0;
            lo_n  <= 32'b0;
            HI    <= 32'b0;
            LO    <= 32'b0;
        end else if (state == RUN) begin
            if (count == '0) begin
                HI    <= hi_n;
                LO    <= lo_n;
                state <= IDLE;
            end else begin
                count <= count - 1'b1;
            end
        end else if (start) begin
            if (md_op) begin
                hi_n  <= res_hi;
                lo_n  <= res_lo;
                count <= (MDop == OP_MULT || MDop == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                state <= RUN;
            end else if (MDop == OP_MTHI) begin
                HI <= srcA;
            end else if (MDop == OP_MTLO) begin
                LO <= srcA;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-written corner
// sequences and random ops checked against an arithmetic reference model.
module tb_mdu;

    logic        clk;
    logic        rst_n;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [2:0]  MDop;
    logic        start;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int nChecks = 0;
    int nPass   = 0;

    logic [31:0] mHi;
    logic [31:0] mLo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[11];

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .srcA(srcA),
        .srcB(srcB),
        .MDop(MDop),
        .start(start),
        .busy(busy),
        .md_stall(md_stall),
        .HI(HI),
        .LO(LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    function automatic bit isMd(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic int opCycles(input logic [2:0] op);
        return (op <= 3'd2) ? 5 : 10;
    endfunction

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] hiIn, input logic [31:0] loIn,
                                     output logic [31:0] hiOut, output logic [31:0] loOut);
        longint sa, sb, p, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hiOut = hiIn;
        loOut = loIn;
        case (op)
            3'd1: begin p = sa * sb; hiOut = p[63:32]; loOut = p[31:0]; end
            3'd2: begin u = {32'b0, a} * {32'b0, b}; hiOut = u[63:32]; loOut = u[31:0]; end
            3'd3: begin
                if (b == 32'b0) begin hiOut = a; loOut = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; hiOut = r[31:0]; loOut = q[31:0]; end
            end
            3'd4: begin
                if (b == 32'b0) begin hiOut = a; loOut = 32'hFFFF_FFFF; end
                else begin hiOut = a % b; loOut = a / b; end
            end
            3'd5: hiOut = a;
            3'd6: loOut = a;
            default: ;
        endcase
    endfunction

    // Issues one op at the current cycle (entered just after a rising edge)
    // and walks through its whole latency; intrudeAt >= 0 drives a mthi on
    // that busy cycle, which must be ignored.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expHi, input logic [31:0] expLo, input int intrudeAt);
        int n;
        start = 1'b1;
        MDop  = op;
        srcA  = a;
        srcB  = b;
        #1;
        checkOutput("md_stall_issue", {31'b0, md_stall}, {31'b0, isMd(op)});
        @(posedge clk);
        #1;
        start = 1'b0;
        MDop  = 3'd0;
        if (isMd(op)) begin
            n = opCycles(op);
            for (int i = 0; i < n; i++) begin
                if (i == intrudeAt) begin
                    start = 1'b1;
                    MDop  = 3'd5;
                    srcA  = 32'h0000_1234;
                end
                #1;
                checkOutput("busy_run", {31'b0, busy}, 32'd1);
                checkOutput("md_stall_run", {31'b0, md_stall}, 32'd1);
                checkOutput("hi_hold", HI, mHi);
                checkOutput("lo_hold", LO, mLo);
                @(posedge clk);
                #1;
                start = 1'b0;
                MDop  = 3'd0;
            end
            checkOutput("md_stall_done", {31'b0, md_stall}, 32'd0);
        end
        checkOutput("busy_done", {31'b0, busy}, 32'd0);
        checkOutput("hi_result", HI, expHi);
        checkOutput("lo_result", LO, expLo);
        mHi = expHi;
        mLo = expLo;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd4, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
        vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5]  = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6]  = '{3'd6, 32'hDEAD_BEEF, 32'd0,         32'd2,         32'hDEAD_BEEF};
        vecs[7]  = '{3'd2, 32'd2,         32'd3,         32'd0,         32'd6};
        vecs[8]  = '{3'd5, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'd6};
        vecs[9]  = '{3'd3, 32'hFFFF_FF85, 32'd0,         32'hFFFF_FF85, 32'hFFFF_FFFF};
        vecs[10] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

        rst_n = 1'b0;
        start = 1'b0;
        MDop  = 3'd0;
        srcA  = 32'd0;
        srcB  = 32'd0;
        mHi   = 32'd0;
        mLo   = 32'd0;

        #12;
        checkOutput("reset_hi", HI, 32'd0);
        checkOutput("reset_lo", LO, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_stall", {31'b0, md_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 11; i++)
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, -1);

        $display("[TB] mthi during busy is ignored");
        applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);

        $display("[TB] random ops against reference model");
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            refModel(op, a, b, mHi, mLo, eh, el);
            applyStimulus(op, a, b, eh, el, -1);
        end

        $display("[TB] reset during RUN");
        applyStimulus(3'd5, 32'hCAFE_F00D, 32'd0, 32'hCAFE_F00D, mLo, -1);
        start = 1'b1;
        MDop  = 3'd3;
        srcA  = 32'd1000;
        srcB  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        MDop  = 3'd0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_run_hi", HI, 32'd0);
        checkOutput("rst_run_lo", LO, 32'd0);
        checkOutput("rst_run_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("post_rst_hi", HI, 32'd0);
        checkOutput("post_rst_lo", LO, 32'd0);
        checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);
        mHi = 32'd0;
        mLo = 32'd0;
        applyStimulus(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, -1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
